hans_cpu: RTL and testbench

Multi-cycle 32-bit load/store processor core with separate word-addressed instruction and data memory ports using request/acknowledge handshakes. Sits between an instruction RAM and a data RAM of the codebase's memory type. Executes one instruction at a time: fetch, execute, optional memory access.

---
 rtl/hans_cpu_pkg.sv | 55 +++++
 rtl/hans_regfile.sv | 31 +++
 rtl/ram.sv | 32 +++
 rtl/hans_cpu.sv | 161 ++++++++++++++++
 tb/tb_hans_cpu.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hans_cpu_pkg.sv
// Shared definitions for the hans_cpu core: datapath widths, FSM states,
// instruction field positions, opcode/func constants and immediate helpers.
package hans_cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } stateT;

    // Instruction field bit positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    localparam int FN_HI  = 10;
    localparam int IMM_HI = 15;
    localparam int OFF_HI = 25;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JMP   = 6'b010000;
    localparam logic [5:0] OP_BEQ   = 6'b010010;
    localparam logic [5:0] OP_BNE   = 6'b010011;
    localparam logic [5:0] OP_ADDI  = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101101;

    // R-type function codes
    localparam logic [10:0] FN_ADD = 11'd0;
    localparam logic [10:0] FN_SUB = 11'd1;
    localparam logic [10:0] FN_AND = 11'd2;
    localparam logic [10:0] FN_OR  = 11'd3;
    localparam logic [10:0] FN_XOR = 11'd4;
    localparam logic [10:0] FN_SLL = 11'd5;
    localparam logic [10:0] FN_SRL = 11'd6;
    localparam logic [10:0] FN_SRA = 11'd7;
    localparam logic [10:0] FN_SLT = 11'd8;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage

// File: rtl/hans_regfile.sv
// 32 x 32-bit register file, two combinational read ports and one write port.
// r0 always reads zero and ignores writes.
module hans_regfile
    import hans_cpu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [REG_AW-1:0] readAddrA,
    input  logic [REG_AW-1:0] readAddrB,
    output logic [DATA_W-1:0] readDataA,
    output logic [DATA_W-1:0] readDataB,
    input  logic              writeEn,
    input  logic [REG_AW-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData
);

    logic [DATA_W-1:0] regs [32];

    // Register storage: cleared on reset, r0 never written
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (writeEn && (writeAddr != '0)) begin
            regs[writeAddr] <= writeData;
        end
    end

    assign readDataA = (readAddrA == '0) ? '0 : regs[readAddrA];
    assign readDataB = (readAddrB == '0) ? '0 : regs[readAddrB];

endmodule

// File: rtl/ram.sv
// Word-addressed single-port RAM with one-cycle read latency and
// registered read/write completion flags. Contents are not reset.
module ram #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
) (
    input  logic                Clock,
    input  logic [31:0]         Adresse,
    input  logic [WORDSIZE-1:0] DatenRein,
    input  logic                SchreibenAn,
    input  logic                LesenAn,
    output logic [WORDSIZE-1:0] DatenRaus,
    output logic                DatenGeschrieben,
    output logic                DatenBereit
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [WORDSIZE-1:0] Daten [WORDS];
    logic [AW-1:0]       index;

    assign index = AW'(Adresse % WORDS);

    // Array access plus one-cycle completion flags; reads see the old word
    always_ff @(posedge Clock) begin
        DatenGeschrieben <= SchreibenAn;
        DatenBereit      <= LesenAn;
        if (SchreibenAn) Daten[index] <= DatenRein;
        if (LesenAn)     DatenRaus    <= Daten[index];
    end

endmodule

// File: rtl/hans_cpu.sv
// hans_cpu: multi-cycle 32-bit load/store core. One instruction at a time
// through FETCH -> EXEC -> (MEM) using request/acknowledge memory ports.
module hans_cpu
    import hans_cpu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Instruktion,
    input  logic              InstruktionGeladen,
    input  logic [DATA_W-1:0] DatenRein,
    input  logic              DatenGeladen,
    input  logic              DatenGespeichert,
    output logic [DATA_W-1:0] InstruktionAdresse,
    output logic              LeseInstruktion,
    output logic [DATA_W-1:0] DatenAdresse,
    output logic [DATA_W-1:0] DatenRaus,
    output logic              LeseDaten,
    output logic              SchreibeDaten
);

    stateT                    state;
    logic [DATA_W-1:0]        pc;
    logic [DATA_W-1:0]        instr;

    logic [5:0]               op;
    logic [REG_AW-1:0]        rd, ra, rb;
    logic [10:0]              func;
    logic signed [DATA_W-1:0] imm, off;

    logic [DATA_W-1:0]        valA, valB;
    logic signed [DATA_W-1:0] sA, sB;
    logic [DATA_W-1:0]        aluRes;
    logic                     aluWr;
    logic [DATA_W-1:0]        memAddr;

    logic                     wrEn;
    logic [DATA_W-1:0]        wrData;
    logic                     memDone;

    assign op   = instr[OP_HI:OP_LO];
    assign rd   = instr[RD_HI:RD_LO];
    assign ra   = instr[RA_HI:RA_LO];
    assign rb   = instr[RB_HI:RB_LO];
    assign func = instr[FN_HI:0];
    assign imm  = sext16(instr[IMM_HI:0]);
    assign off  = sext26(instr[OFF_HI:0]);

    assign sA      = valA;
    assign sB      = valB;
    assign memAddr = valA + imm;
    assign memDone = (LeseDaten && DatenGeladen) || (SchreibeDaten && DatenGespeichert);

    assign InstruktionAdresse = pc;

    // Port B serves rB for R-type and rD for branches and stores
    hans_regfile uRegs (
        .Clock     (Clock),
        .Reset     (Reset),
        .readAddrA (ra),
        .readAddrB ((op == OP_RTYPE) ? rb : rd),
        .readDataA (valA),
        .readDataB (valB),
        .writeEn   (wrEn),
        .writeAddr (rd),
        .writeData (wrData)
    );

    // Inline ALU for R-type operations; unknown func codes suppress the write
    always_comb begin
        aluRes = '0;
        aluWr  = 1'b1;
        case (func)
            FN_ADD:  aluRes = valA + valB;
            FN_SUB:  aluRes = valA - valB;
            FN_AND:  aluRes = valA & valB;
            FN_OR:   aluRes = valA | valB;
            FN_XOR:  aluRes = valA ^ valB;
            FN_SLL:  aluRes = valA << valB[4:0];
            FN_SRL:  aluRes = valA >> valB[4:0];
            FN_SRA:  aluRes = sA >>> valB[4:0];
            FN_SLT:  aluRes = {{(DATA_W-1){1'b0}}, (sA < sB)};
            default: aluWr  = 1'b0;
        endcase
    end

    // Register write selection: ALU/ADDI results in EXEC, load data on MEM completion
    always_comb begin
        wrEn   = 1'b0;
        wrData = aluRes;
        if (state == EXEC) begin
            if (op == OP_RTYPE) begin
                wrEn = aluWr;
            end else if (op == OP_ADDI) begin
                wrEn   = 1'b1;
                wrData = valA + imm;
            end
        end else if (state == MEM && LeseDaten && DatenGeladen) begin
            wrEn   = 1'b1;
            wrData = DatenRein;
        end
    end

    // Control FSM with registered memory-port outputs and PC update
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state           <= FETCH;
            pc              <= '0;
            instr           <= '0;
            LeseInstruktion <= 1'b0;
            DatenAdresse    <= '0;
            DatenRaus       <= '0;
            LeseDaten       <= 1'b0;
            SchreibeDaten   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    LeseInstruktion <= 1'b1;
                    if (LeseInstruktion && InstruktionGeladen) begin
                        instr           <= Instruktion;
                        LeseInstruktion <= 1'b0;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    state           <= FETCH;
                    LeseInstruktion <= 1'b1;
                    case (op)
                        OP_JMP: pc <= pc + off;
                        OP_BEQ: pc <= (valB == valA) ? pc + imm : pc + 32'd1;
                        OP_BNE: pc <= (valB != valA) ? pc + imm : pc + 32'd1;
                        OP_LW: begin
                            DatenAdresse    <= memAddr;
                            LeseDaten       <= 1'b1;
                            LeseInstruktion <= 1'b0;
                            state           <= MEM;
                        end
                        OP_SW: begin
                            DatenAdresse    <= memAddr;
                            DatenRaus       <= valB;
                            SchreibeDaten   <= 1'b1;
                            LeseInstruktion <= 1'b0;
                            state           <= MEM;
                        end
                        default: pc <= pc + 32'd1;
                    endcase
                end
                MEM: begin
                    if (memDone) begin
                        LeseDaten       <= 1'b0;
                        SchreibeDaten   <= 1'b0;
                        pc              <= pc + 32'd1;
                        LeseInstruktion <= 1'b1;
                        state           <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hans_cpu.sv
// Testbench for hans_cpu: instructions served from the bench, data memory is
// the ram module behind a bench-controlled acknowledge delay gate. An
// instruction-level model tracks registers, PC and data memory.
module tb_hans_cpu;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Instruktion = '0;
    logic        InstruktionGeladen = 1'b0;
    logic [31:0] DatenRein;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic [31:0] InstruktionAdresse;
    logic        LeseInstruktion;
    logic [31:0] DatenAdresse;
    logic [31:0] DatenRaus;
    logic        LeseDaten;
    logic        SchreibeDaten;

    // data RAM hookup: preload port during reset, then CPU port behind the gate
    logic        preload = 1'b1;
    logic        gate    = 1'b0;
    logic [31:0] pAddr = '0, pData = '0;
    logic        pWe = 1'b0;
    logic [31:0] ramAdr, ramDin;
    logic        ramWe, ramRe;

    assign ramAdr = preload ? pAddr : DatenAdresse;
    assign ramDin = preload ? pData : DatenRaus;
    assign ramWe  = preload ? pWe   : (SchreibeDaten & gate);
    assign ramRe  = preload ? 1'b0  : (LeseDaten & gate);

    always #5 Clock = ~Clock;

    hans_cpu dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Instruktion        (Instruktion),
        .InstruktionGeladen (InstruktionGeladen),
        .DatenRein          (DatenRein),
        .DatenGeladen       (DatenGeladen),
        .DatenGespeichert   (DatenGespeichert),
        .InstruktionAdresse (InstruktionAdresse),
        .LeseInstruktion    (LeseInstruktion),
        .DatenAdresse       (DatenAdresse),
        .DatenRaus          (DatenRaus),
        .LeseDaten          (LeseDaten),
        .SchreibeDaten      (SchreibeDaten)
    );

    ram #(.WORDSIZE(32), .WORDS(256)) dataRam (
        .Clock            (Clock),
        .Adresse          (ramAdr),
        .DatenRein        (ramDin),
        .SchreibenAn      (ramWe),
        .LesenAn          (ramRe),
        .DatenRaus        (DatenRein),
        .DatenGeschrieben (DatenGespeichert),
        .DatenBereit      (DatenGeladen)
    );

    int cmpCount = 0;
    int errCount = 0;

    // architectural model
    logic [31:0] mReg [32];
    logic [31:0] mMem [256];
    logic [31:0] mPc;

    logic [31:0] lastStore, lastAddr, lastFetch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encR(input int rd, input int ra, input int rb, input int fn);
        logic [4:0] d, a, b;
        logic [10:0] f;
        d = 5'(rd); a = 5'(ra); b = 5'(rb); f = 11'(fn);
        return {6'b000000, d, a, b, f};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input int rd, input int ra, input logic [15:0] imm);
        logic [4:0] d, a;
        d = 5'(rd); a = 5'(ra);
        return {op, d, a, imm};
    endfunction

    function automatic logic [31:0] encJ(input logic [31:0] offs);
        return {6'b010000, offs[25:0]};
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 10);
        case (sel)
            0, 1, 2: return {6'b000000, r[25:11], 7'b0, r[3:0]};
            3:       return {6'b010000, r[25:0]};
            4:       return {6'b010010, r[25:0]};
            5:       return {6'b010011, r[25:0]};
            6, 7:    return {6'b100000, r[25:0]};
            8:       return {6'b101000, r[25:0]};
            9:       return {6'b101101, r[25:0]};
            default: return r;
        endcase
    endfunction

    // Instruction-level semantics; kind 0 = no memory access, 1 = load, 2 = store
    task automatic modelExec(input logic [31:0] ins, output int kind,
                             output logic [31:0] addr, output logic [31:0] sdata);
        logic [5:0]  op;
        logic [31:0] a, b, d, imm, res;
        logic [4:0]  sh;
        int          rd;
        bit          wr;
        op    = ins[31:26];
        rd    = int'(ins[25:21]);
        a     = mReg[ins[20:16]];
        b     = mReg[ins[15:11]];
        d     = mReg[ins[25:21]];
        imm   = {{16{ins[15]}}, ins[15:0]};
        sh    = b[4:0];
        kind  = 0;
        addr  = '0;
        sdata = '0;
        wr    = 1'b0;
        res   = '0;
        case (op)
            6'b000000: begin
                wr = 1'b1;
                case (int'(ins[10:0]))
                    0: res = a + b;
                    1: res = a - b;
                    2: res = a & b;
                    3: res = a | b;
                    4: res = a ^ b;
                    5: res = a << sh;
                    6: res = a >> sh;
                    7: begin
                        res = a >> sh;
                        if (a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
                    end
                    8: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
                mPc = mPc + 1;
            end
            6'b010000: mPc = mPc + {{6{ins[25]}}, ins[25:0]};
            6'b010010: mPc = (d == a) ? mPc + imm : mPc + 1;
            6'b010011: mPc = (d != a) ? mPc + imm : mPc + 1;
            6'b100000: begin
                wr  = 1'b1;
                res = a + imm;
                mPc = mPc + 1;
            end
            6'b101000: begin
                kind = 1;
                addr = a + imm;
                wr   = 1'b1;
                res  = mMem[addr % 256];
                mPc  = mPc + 1;
            end
            6'b101101: begin
                kind  = 2;
                addr  = a + imm;
                sdata = d;
                mMem[addr % 256] = d;
                mPc   = mPc + 1;
            end
            default: mPc = mPc + 1;
        endcase
        if (wr && rd != 0) mReg[rd] = res;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = '0;
        mPc = '0;
    endtask

    task automatic waitFetch(output logic [31:0] a);
        int n;
        n = 0;
        while (LeseInstruktion !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("fetchTimeout", 32'(LeseInstruktion), 32'd1);
        a = InstruktionAdresse;
    endtask

    // One complete instruction: fetch handshake, execute, optional data handshake
    task automatic runInstr(input logic [31:0] ins, input int iDelay, input int dDelay, input int resetAt);
        int          kind;
        logic [31:0] eAddr, eData;
        bit          acked;
        waitFetch(lastFetch);
        check("fetchAddr", lastFetch, mPc);
        for (int i = 0; i < iDelay; i++) begin
            @(negedge Clock);
            check("fetchHoldReq", 32'(LeseInstruktion), 32'd1);
            check("fetchHoldAddr", InstruktionAdresse, lastFetch);
        end
        Instruktion        = ins;
        InstruktionGeladen = 1'b1;
        @(negedge Clock);
        check("fetchReqDrop", 32'(LeseInstruktion), 32'd0);
        // stray acknowledge while executing must be ignored
        Instruktion        = $urandom;
        InstruktionGeladen = 1'($urandom_range(0, 1));
        modelExec(ins, kind, eAddr, eData);
        @(negedge Clock);
        InstruktionGeladen = 1'b0;
        if (kind != 0) begin
            check("memReq", {30'b0, LeseDaten, SchreibeDaten}, (kind == 1) ? 32'd2 : 32'd1);
            check("memAddr", DatenAdresse, eAddr);
            if (kind == 2) check("storeData", DatenRaus, eData);
            lastStore = DatenRaus;
            lastAddr  = DatenAdresse;
            acked     = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (c == resetAt) begin
                    Reset = 1'b0;
                    #1;
                    check("midRstReqs", {29'b0, LeseInstruktion, LeseDaten, SchreibeDaten}, 32'd0);
                    check("midRstIAddr", InstruktionAdresse, 32'd0);
                    check("midRstDAddr", DatenAdresse, 32'd0);
                    check("midRstDOut", DatenRaus, 32'd0);
                    modelReset();
                    gate = 1'b0;
                    InstruktionGeladen = 1'b0;
                    repeat (2) @(negedge Clock);
                    Reset = 1'b1;
                    return;
                end
                if (c >= dDelay) gate = 1'b1;
                Instruktion        = $urandom;
                InstruktionGeladen = 1'($urandom_range(0, 1));
                @(negedge Clock);
                check("memHoldAddr", DatenAdresse, eAddr);
                if (kind == 2) check("memHoldData", DatenRaus, eData);
                check("memFetchIdle", 32'(LeseInstruktion), 32'd0);
                if (DatenGeladen || DatenGespeichert) begin
                    acked = 1'b1;
                    break;
                end
            end
            gate               = 1'b0;
            InstruktionGeladen = 1'b0;
            check("memAck", 32'(acked), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] fa;
        modelReset();
        for (int i = 0; i < 256; i++) mMem[i] = $urandom;
        mMem[7] = 32'hDEAD_BEEF;

        // preload data RAM while the core is held in reset
        repeat (3) @(negedge Clock);
        check("rstReqs", {29'b0, LeseInstruktion, LeseDaten, SchreibeDaten}, 32'd0);
        check("rstIAddr", InstruktionAdresse, 32'd0);
        check("rstDAddr", DatenAdresse, 32'd0);
        check("rstDOut", DatenRaus, 32'd0);
        for (int i = 0; i < 256; i++) begin
            pAddr = i;
            pData = mMem[i];
            pWe   = 1'b1;
            @(negedge Clock);
        end
        pWe = 1'b0;
        @(negedge Clock);
        preload = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("firstFetchReq", 32'(LeseInstruktion), 32'd1);
        check("firstFetchAddr", InstruktionAdresse, 32'd0);

        // ADDI r1 ; SW r1 -> [5] ; JMP -1
        runInstr(32'h8020_0001, 0, 0, -1);
        runInstr(32'hB420_0005, 2, 1, -1);
        check("sw1Data", lastStore, 32'd1);
        check("sw1Addr", lastAddr, 32'd5);
        runInstr(32'h43FF_FFFF, 0, 0, -1);
        runInstr(encI(6'b101000, 5, 0, 16'd5), 0, 0, -1);
        runInstr(encI(6'b101101, 5, 0, 16'd40), 0, 0, -1);
        check("ramReadBack", lastStore, 32'd1);

        // Fibonacci chain r10..r20
        runInstr(encI(6'b100000, 10, 0, 16'd1), 0, 0, -1);
        runInstr(encI(6'b100000, 11, 0, 16'd1), 1, 0, -1);
        for (int k = 12; k <= 20; k++) runInstr(encR(k, k - 1, k - 2, 0), k % 3, 0, -1);
        runInstr(encI(6'b101101, 20, 0, 16'd20), 0, 2, -1);
        check("fibR20", lastStore, 32'd89);

        // SUB / SLT
        runInstr(encR(3, 0, 1, 1), 0, 0, -1);
        runInstr(encR(4, 3, 0, 8), 0, 0, -1);
        runInstr(encI(6'b101101, 3, 0, 16'd30), 0, 0, -1);
        check("subNeg", lastStore, 32'hFFFF_FFFF);
        runInstr(encI(6'b101101, 4, 0, 16'd31), 0, 0, -1);
        check("sltNeg", lastStore, 32'd1);

        // LW with a 4-cycle delayed acknowledge
        runInstr(encI(6'b101000, 2, 0, 16'd7), 0, 4, -1);
        check("lwAddr", lastAddr, 32'd7);
        runInstr(encI(6'b101101, 2, 0, 16'd8), 0, 0, -1);
        check("lwData", lastStore, 32'hDEAD_BEEF);

        // branches at address 10
        runInstr(encJ(32'd10 - mPc), 0, 0, -1);
        runInstr(32'h4800_FFFD, 0, 0, -1);
        waitFetch(fa);
        check("beqTarget", fa, 32'd7);
        runInstr(encJ(32'd10 - mPc), 0, 0, -1);
        runInstr(32'h4C00_FFFD, 0, 0, -1);
        waitFetch(fa);
        check("bneFall", fa, 32'd11);

        // r0 stays zero
        runInstr(encI(6'b100000, 0, 0, 16'h0055), 0, 0, -1);
        runInstr(encI(6'b101101, 0, 0, 16'd9), 0, 0, -1);
        check("r0Zero", lastStore, 32'd0);

        // reset in the middle of a load handshake
        runInstr(encI(6'b101000, 6, 0, 16'd5), 0, 10, 3);

        // random programs
        for (int i = 0; i < 300; i++)
            runInstr(randInstr(), $urandom_range(0, 3), $urandom_range(0, 3), -1);

        // dump every register to memory
        for (int i = 1; i < 32; i++)
            runInstr(encI(6'b101101, i, 0, 16'(100 + i)), 0, $urandom_range(0, 2), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", cmpCount);
        $fatal(1, "time limit");
    end

endmodule
